// File: rtl/reduce_tree_pipe.sv
// rtl/reduce_tree_pipe.sv - pipelined balanced-tree bitwise reduction of NUM_IN lanes with valid/ready
module reduce_tree_pipe #(
  parameter int NUM_IN = 3,
  parameter int DATA_W = 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [1:0]               op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [1:0]               out_op,
  output logic                     busy,
  output logic [CNT_W-1:0]         txn_count
);

  localparam int LEVELS = $clog2(NUM_IN);

  typedef logic [DATA_W-1:0] lane_t;

  // Number of live elements at tree level k (level 0 is the raw lanes).
  function automatic int level_width(input int k);
    int n;
    n = NUM_IN;
    for (int i = 0; i < k; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  function automatic int clamp_lane(input int i);
    return (i < NUM_IN) ? i : NUM_IN - 1;
  endfunction

  // XNOR travels as XOR through the tree; only the final stage inverts.
  function automatic lane_t combine(input lane_t a, input lane_t b, input logic [1:0] o);
    lane_t r;
    case (o)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  lane_t            node    [LEVELS][NUM_IN];
  logic [1:0]       op_src  [LEVELS];
  logic [LEVELS-1:0] vld_src;

  lane_t            stage_q [1:LEVELS][NUM_IN];
  lane_t            stage_d [1:LEVELS][NUM_IN];
  logic [1:0]       op_q    [1:LEVELS];
  logic [1:0]       op_d    [1:LEVELS];
  logic [LEVELS:1]  v_q;
  logic [LEVELS:1]  v_d;
  logic [LEVELS:1]  rdy;
  logic [CNT_W-1:0] txn_count_q;
  logic [CNT_W-1:0] txn_count_d;

  always_comb begin
    rdy = '0;
    rdy[LEVELS] = !v_q[LEVELS] || out_ready;
    for (int s = LEVELS - 1; s >= 1; s--) begin
      rdy[s] = !v_q[s] || rdy[s+1];
    end
  end

  assign in_ready = rdy[1];

  // Source operands feeding stage s+1: the input port for s=0, else stage s registers.
  always_comb begin
    vld_src = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      node[0][j] = in_data[j*DATA_W +: DATA_W];
    end
    op_src[0]  = op;
    vld_src[0] = in_valid && in_ready;
    for (int s = 1; s < LEVELS; s++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        node[s][j] = stage_q[s][j];
      end
      op_src[s]  = op_q[s];
      vld_src[s] = v_q[s];
    end
  end

  always_comb begin
    int n_prev;
    n_prev = 0;
    v_d    = v_q;
    for (int s = 1; s <= LEVELS; s++) begin
      op_d[s] = op_q[s];
      for (int j = 0; j < NUM_IN; j++) begin
        stage_d[s][j] = stage_q[s][j];
      end
    end

    for (int s = 1; s <= LEVELS; s++) begin
      if (rdy[s]) begin
        v_d[s]  = vld_src[s-1];
        op_d[s] = op_src[s-1];
        n_prev  = level_width(s - 1);
        for (int j = 0; j < NUM_IN; j++) begin
          if (2*j + 1 < n_prev) begin
            stage_d[s][j] = combine(node[s-1][clamp_lane(2*j)],
                                    node[s-1][clamp_lane(2*j + 1)], op_src[s-1]);
          end else if (2*j < n_prev) begin
            stage_d[s][j] = node[s-1][clamp_lane(2*j)];
          end else begin
            stage_d[s][j] = '0;
          end
        end
        if (s == LEVELS && op_src[s-1] == 2'b11) begin
          stage_d[s][0] = ~stage_d[s][0];
        end
      end
    end
  end

  always_comb begin
    txn_count_d = txn_count_q;
    if (out_valid && out_ready) begin
      txn_count_d = txn_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      txn_count_q <= '0;
      for (int s = 1; s <= LEVELS; s++) begin
        op_q[s] <= '0;
        for (int j = 0; j < NUM_IN; j++) begin
          stage_q[s][j] <= '0;
        end
      end
    end else begin
      v_q         <= v_d;
      txn_count_q <= txn_count_d;
      op_q        <= op_d;
      stage_q     <= stage_d;
    end
  end

  assign out_valid = v_q[LEVELS];
  assign out_data  = stage_q[LEVELS][0];
  assign out_op    = op_q[LEVELS];
  assign busy      = |v_q;
  assign txn_count = txn_count_q;

endmodule
